s1_tag_array: RTL
=================

# s1_tag_array

Parametrised multi-way tag array for the reduced S1 core's cache (I-cache or D-cache tag store), replacing the fixed 4-way/128-set/33-bit array and its per-way ports with packed buses. It takes x-stage index/request, returns all ways' tags in y-stage, and accepts write data in y-stage. It adds behaviour the fixed array lacks: a hardware clear sequencer run after reset and on flush, and a same-index write-to-read bypass.

## Interface
- WAYS, 4, number of ways (1–8)
- IDX_W, 7, index width; 2^IDX_W sets
- TAG_W, 33, tag width including valid/parity bits

- rclk  in  1  clock
- reset  in  1  synchronous, active-high reset
- index0_x  in  IDX_W  index source 0
- index1_x  in  IDX_W  index source 1
- index_sel_x  in  1  1 selects index1_x, 0 selects index0_x
- rdreq_x  in  1  read request
- wrreq_x  in  1  write request
- dec_wrway_x  in  WAYS  one-hot-or-multi way write mask
- wrtag_y  in  WAYS*TAG_W  write data, way w at [w*TAG_W +: TAG_W], sampled in y
- flush_req  in  1  request full clear of the array
- rdtag_y  out  WAYS*TAG_W  read data, same packing
- busy  out  1  clear in progress; requests ignored

## Operation
- Index mux: idx_x = index_sel_x ? index1_x : index0_x.
- Read: rdreq_x at edge t registers idx; rdtag_y valid during cycle t+1 (all ways). With no read, rdtag_y holds its previous value.
- Write: wrreq_x at edge t registers idx and dec_wrway_x; wrtag_y sampled at edge t+1 and written to each way whose mask bit is set. Mask all-zero: no-op.
- Read and write issued in the same x cycle at the same index: read returns pre-write contents.
- Bypass: read at edge t+1 to the same index as a write committing at edge t+1 returns wrtag_y for masked ways and array data for the others. It never returns stale data.
- FSM states: IDLE, CLEAR.
  - reset forces CLEAR, clear counter = 0, and rdtag_y = 0.
  - In CLEAR, one index per cycle is written with zero in all ways. The counter increments and wraps to 0 after 2^IDX_W−1, and the FSM then returns to IDLE.
- flush_req in IDLE is sampled at edge t. busy=1 from cycle t+1, and the first clear write is at edge t+1.
- flush_req in CLEAR is ignored; the clear is not restarted.
- While busy, rdreq_x/wrreq_x are dropped and rdtag_y holds.
- A y-write pending when CLEAR begins is discarded, because the clear owns the write port. The final contents are all-zero either way.
- Reset during CLEAR restarts the clear at index 0.

## Timing
- Reset values: rdtag_y = 0, busy = 1 (CLEAR), clear counter = 0.
- Read latency: 1 cycle (x→y).
- Write commit: at the end of the y cycle.
- Clear duration: exactly 2^IDX_W cycles with busy=1. busy falls in the cycle after the last index is written, and the first accepted request is in that same cycle.
- Throughput: one read and one write per cycle, with no stalls outside CLEAR.

## Structure
- Package s1_tag_array_pkg holds:
  - FSM state enum (ST_IDLE, ST_CLEAR)
  - default parameter constants
  - the packed-slice helper function for way w
- Sub-module s1_tag_ram, one instance per way:
  - 2^IDX_W × TAG_W, one read port and one write port, registered read, no reset on storage.
  - Parent owns the index mux, the y-stage registers, the bypass mux and the FSM.

## Test plan
- Reset, then 128 cycles idle: busy is 1 for exactly 128 cycles; after that, reading index 0x00 and 0x7F returns all-zero tags.
- Write index 0x15, mask 4'b0101, wrtag_y way0 = 0x1_2345_6789 and way2 = 0x0_DEAD_BEEF; then read 0x15 → way0/way2 return the written values and way1/way3 return 0.
- Write 0x22 with mask 4'b1000 and data 0x1_AAAA_AAAA, and read 0x22 in the next x cycle → bypass returns 0x1_AAAA_AAAA on way3, with no stale value.
- Same-cycle rdreq_x + wrreq_x at 0x30 (old way1 = 0x5, new = 0x7, mask 4'b0010) → read returns 0x5; a later read returns 0x7.
- flush_req after filling indices 0x00–0x7F with nonzero data, with a second flush_req 10 cycles later → busy for exactly 128 cycles (the second flush is ignored), all reads are then 0, and rdreq_x during busy leaves rdtag_y unchanged.
- Assert reset at cycle 50 of a clear → the clear restarts and busy stays high 128 cycles from the reset edge; repeat with WAYS=2, IDX_W=4, TAG_W=20 → 16-cycle clear and correct packed slices.

Source files
------------

// File: rtl/s1_tag_array_pkg.sv
// Shared types and defaults for the S1 multi-way cache tag array.
// Way w of a packed tag bus lives at [way_lo(w, TAG_W) +: TAG_W].
package s1_tag_array_pkg;

  localparam int DEF_WAYS  = 4;
  localparam int DEF_IDX_W = 7;
  localparam int DEF_TAG_W = 33;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  function automatic int way_lo(input int w, input int tag_w);
    return w * tag_w;
  endfunction

endpackage

// File: rtl/s1_tag_ram.sv
// One way of tag storage: one read port and one write port.
// The read is registered and holds when not enabled; storage is not reset.
module s1_tag_ram #(
  parameter int IDX_W = 7,
  parameter int TAG_W = 33
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [TAG_W-1:0] rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_data
);

  logic [TAG_W-1:0] mem [2**IDX_W];

  // A read and a write to one index on one edge return the old contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/s1_tag_array.sv
// Multi-way tag array: x-stage index/request, y-stage tags and write data,
// with a clear sequencer after reset/flush and a write-to-read bypass.
module s1_tag_array
  import s1_tag_array_pkg::*;
#(
  parameter int WAYS  = DEF_WAYS,
  parameter int IDX_W = DEF_IDX_W,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic                  rclk,
  input  logic                  reset,
  input  logic [IDX_W-1:0]      index0_x,
  input  logic [IDX_W-1:0]      index1_x,
  input  logic                  index_sel_x,
  input  logic                  rdreq_x,
  input  logic                  wrreq_x,
  input  logic [WAYS-1:0]       dec_wrway_x,
  input  logic [WAYS*TAG_W-1:0] wrtag_y,
  input  logic                  flush_req,
  output logic [WAYS*TAG_W-1:0] rdtag_y,
  output logic                  busy
);

  state_e                state;
  logic [IDX_W-1:0]      clr_cnt;
  logic [IDX_W-1:0]      idx_x;
  logic [IDX_W-1:0]      wr_idx_q;
  logic [WAYS-1:0]       wr_mask_q;
  logic                  wr_v_q;
  logic                  zero_q;
  logic [WAYS-1:0]       byp_q;
  logic [WAYS*TAG_W-1:0] byp_data_q;

  logic                  idle;
  logic                  clearing;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  byp_hit;
  logic                  rd_en;
  logic [IDX_W-1:0]      wr_idx;
  logic [WAYS*TAG_W-1:0] wr_data;
  logic [WAYS-1:0]       wr_en;

  assign idx_x    = index_sel_x ? index1_x : index0_x;
  assign idle     = (state == ST_IDLE);
  assign clearing = (state == ST_CLEAR);
  assign busy     = clearing;
  assign rd_acc   = idle & rdreq_x;
  assign wr_acc   = idle & wrreq_x;
  assign byp_hit  = wr_v_q & (wr_idx_q == idx_x);
  assign rd_en    = ~reset & rd_acc;

  // The clear owns the write port; a pending y-write is dropped.
  assign wr_idx  = clearing ? clr_cnt : wr_idx_q;
  assign wr_data = clearing ? '0 : wrtag_y;
  assign wr_en   = reset    ? '0
                 : clearing ? {WAYS{1'b1}}
                 : (wr_v_q ? wr_mask_q : '0);

  always_ff @(posedge rclk) begin
    if (reset) begin
      state      <= ST_CLEAR;
      clr_cnt    <= '0;
      wr_v_q     <= 1'b0;
      wr_idx_q   <= '0;
      wr_mask_q  <= '0;
      zero_q     <= 1'b1;
      byp_q      <= '0;
      byp_data_q <= '0;
    end else begin
      wr_v_q <= wr_acc;
      if (wr_acc) begin
        wr_idx_q  <= idx_x;
        wr_mask_q <= dec_wrway_x;
      end
      if (rd_acc) begin
        zero_q     <= 1'b0;
        byp_q      <= byp_hit ? wr_mask_q : '0;
        byp_data_q <= wrtag_y;
      end
      unique case (state)
        ST_IDLE: begin
          if (flush_req) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end
        end
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + IDX_W'(1);
          if (&clr_cnt) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    localparam int LO = way_lo(w, TAG_W);
    logic [TAG_W-1:0] q;

    s1_tag_ram #(
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
    ) u_ram (
      .clk     (rclk),
      .rd_en   (rd_en),
      .rd_idx  (idx_x),
      .rd_data (q),
      .wr_en   (wr_en[w]),
      .wr_idx  (wr_idx),
      .wr_data (wr_data[LO +: TAG_W])
    );

    assign rdtag_y[LO +: TAG_W] =
      zero_q   ? '0 :
      byp_q[w] ? byp_data_q[LO +: TAG_W] : q;
  end

endmodule
